window_4x4_gen: RTL
===================

Name: window_4x4_gen

Overview:
- Sits directly downstream of the 4-row line buffer in the upscaler datapath.
- Takes the four vertically aligned row taps (current row plus three delayed rows) once per accepted pixel.
- Shifts them into a 4x4 pixel window and tracks image row/column.
- Emits a valid 4x4 neighbourhood with its image coordinates to the bicubic interpolation stage.

Parameters:
- DATA_WIDTH, 8, bits per pixel (matches line buffer).
- IMG_WIDTH, 128, pixels per row (matches line buffer).
- IMG_HEIGHT, 128, rows per frame.
- CW, $clog2(IMG_WIDTH), column coordinate width (derived, localparam).
- RW, $clog2(IMG_HEIGHT), row coordinate width (derived, localparam).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ce  in  1  pixel accept strobe; same strobe drives the line buffer ce
- sof  in  1  start of frame; qualified by ce, marks pixel (0,0)
- tap0  in  DATA_WIDTH  current-row pixel (line buffer dout_0)
- tap1  in  DATA_WIDTH  row-1 pixel (dout_1)
- tap2  in  DATA_WIDTH  row-2 pixel (dout_2)
- tap3  in  DATA_WIDTH  row-3 pixel (dout_3)
- win  out  16*DATA_WIDTH  flattened window; element w[r][c] at bits [(r*4+c)*DATA_WIDTH +: DATA_WIDTH]
- win_valid  out  1  one-cycle pulse: win/win_x/win_y valid
- win_x  out  CW  column of window top-left (oldest column)
- win_y  out  RW  row of window top-left (oldest row)
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted
- sof_err  out  1  one-cycle pulse: sof seen mid-frame (resync)

Behaviour:
- Reset (rst=1 at clk edge):
  - win = 0, win_valid = 0, win_x = 0, win_y = 0, frame_done = 0, sof_err = 0.
  - col/row counters = 0; state = IDLE.
  - Reset overrides ce/sof in the same cycle; reset mid-frame discards the frame.
- Window shift, only on an accepted pixel (ce=1 in FILL/RUN, or ce&sof in IDLE):
  - For r=0..3: w[r][3]<=w[r][2], w[r][2]<=w[r][1], w[r][1]<=w[r][0], w[r][0]<=tap_r.
  - Column 0 holds the newest pixel; row 0 is the current image row, row 3 the oldest.
  - ce=0: window, counters and state hold; win_valid, frame_done and sof_err are 0.
- Coordinates: accepted pixel position (row,col); col increments per accept and wraps IMG_WIDTH-1 -> 0 with row+1.
- States:
  - IDLE: ce&sof -> pixel is (0,0), col<=1, go FILL. ce without sof is ignored (no shift, no counter change).
  - FILL: row<3. Accept after (2,IMG_WIDTH-1) -> RUN.
  - RUN: row>=3. Accept of (IMG_HEIGHT-1, IMG_WIDTH-1) -> IDLE, counters cleared, frame_done=1 next cycle.
  - Any state, ce&sof while in FILL/RUN: pixel treated as (0,0); window cleared, then shifted with taps; sof_err=1 next cycle; go FILL.
- win_valid:
  - Registered; asserted the cycle after accepting pixel (row,col) with row>=3 and col>=3.
  - Then win_x=col-3, win_y=row-3; latency 1 clk from ce.
  - No window straddles a row boundary (col<3 suppressed).
  - Windows per frame = (IMG_WIDTH-3)*(IMG_HEIGHT-3).
- win_x/win_y hold their last value when win_valid=0.
- frame_done and the final win_valid assert in the same cycle.

Optional Feature:
- Macro: WIN_4X4_GEN_CNT_EN.
- Defined:
  - Adds output port win_count (32 bits).
  - Counts win_valid pulses; cleared by rst and by any accepted sof; saturates at 2^32-1.
  - Value after frame_done equals the frame's window count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=8, tapN driven with pixel value row*16+col from a row-delay model):
- Full frame, ce=1 continuous, sof on first pixel -> exactly 15 win_valid pulses. First has win_x=0, win_y=0, w[3][3]=0x00, w[0][0]=0x33. Last has win_x=4, win_y=2, w[0][0]=0x57. frame_done coincides with last.
- Same frame, ce toggled 1/0 every cycle -> identical 15 windows and values; no win_valid while ce=0.
- Pixels with ce=1 but sof=0 after reset -> no outputs, state IDLE. Then sof -> normal frame from (0,0).
- sof reasserted at pixel (4,5) -> sof_err pulse next cycle. Window cleared. Next valid window only after new (3,3), with win_x=0, win_y=0.
- rst asserted at pixel (3,6) for 1 cycle -> all outputs 0 next cycle; ce without sof ignored until new sof.
- WIN_4X4_GEN_CNT_EN defined, two back-to-back frames -> win_count=15 at first frame_done, reset to 0 by second sof, 15 again at second frame_done.

Source files
------------

// File: rtl/window_4x4_gen.sv
// 4x4 sliding pixel window behind the 4-row line buffer, with image row/column tracking.
// Optional: define WIN_4X4_GEN_CNT_EN to add a saturating per-frame window counter (win_count).
module window_4x4_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  localparam int CW = $clog2(IMG_WIDTH),
  localparam int RW = $clog2(IMG_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     sof,
  input  logic [DATA_WIDTH-1:0]    tap0,
  input  logic [DATA_WIDTH-1:0]    tap1,
  input  logic [DATA_WIDTH-1:0]    tap2,
  input  logic [DATA_WIDTH-1:0]    tap3,
  output logic [16*DATA_WIDTH-1:0] win,
  output logic                     win_valid,
  output logic [CW-1:0]            win_x,
  output logic [RW-1:0]            win_y,
  output logic                     frame_done,
  output logic                     sof_err
`ifdef WIN_4X4_GEN_CNT_EN
  ,
  output logic [31:0]              win_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CW-1:0]         col_reg, col_next, pix_col;
  logic [RW-1:0]         row_reg, row_next, pix_row;
  logic                  accept, restart, clear_win, last_pix, valid_next;
  logic                  win_valid_reg, frame_done_reg, sof_err_reg;
  logic [CW-1:0]         win_x_reg;
  logic [RW-1:0]         win_y_reg;
  logic [DATA_WIDTH-1:0] tap_arr [4];

  assign tap_arr[0] = tap0;
  assign tap_arr[1] = tap1;
  assign tap_arr[2] = tap2;
  assign tap_arr[3] = tap3;

  // col_reg/row_reg hold the coordinate of the next pixel to be accepted.
  always_comb begin
    accept     = ce && ((state_reg != IDLE) || sof);
    restart    = accept && sof;
    clear_win  = restart && (state_reg != IDLE);
    pix_col    = restart ? '0 : col_reg;
    pix_row    = restart ? '0 : row_reg;
    last_pix   = (pix_row == RW'(IMG_HEIGHT - 1)) && (pix_col == CW'(IMG_WIDTH - 1));
    valid_next = accept && (pix_row >= RW'(3)) && (pix_col >= CW'(3));
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    if (accept) begin
      if (last_pix) begin
        state_next = IDLE;
        col_next   = '0;
        row_next   = '0;
      end else begin
        if (pix_col == CW'(IMG_WIDTH - 1)) begin
          col_next = '0;
          row_next = pix_row + RW'(1);
        end else begin
          col_next = pix_col + CW'(1);
          row_next = pix_row;
        end
        state_next = (row_next >= RW'(3)) ? RUN : FILL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      win_valid_reg  <= 1'b0;
      win_x_reg      <= '0;
      win_y_reg      <= '0;
      frame_done_reg <= 1'b0;
      sof_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      win_valid_reg  <= valid_next;
      frame_done_reg <= accept && last_pix;
      sof_err_reg    <= clear_win;
      if (valid_next) begin
        win_x_reg <= pix_col - CW'(3);
        win_y_reg <= pix_row - RW'(3);
      end
    end
  end

  // Each window row is its own shift register; column 0 takes the newest tap.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      logic [DATA_WIDTH-1:0] row_pix_reg [4];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int c = 0; c < 4; c++) row_pix_reg[c] <= '0;
        end else if (accept) begin
          row_pix_reg[0] <= tap_arr[gi];
          for (int c = 1; c < 4; c++) row_pix_reg[c] <= clear_win ? '0 : row_pix_reg[c-1];
        end
      end

      for (gj = 0; gj < 4; gj++) begin : g_col
        assign win[(gi*4+gj)*DATA_WIDTH +: DATA_WIDTH] = row_pix_reg[gj];
      end
    end
  endgenerate

`ifdef WIN_4X4_GEN_CNT_EN
  // Counts alongside valid_next so win_count already includes the pulse it is shown with.
  logic [31:0] win_count_reg;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      win_count_reg <= '0;
    end else if (valid_next && (win_count_reg != 32'hFFFF_FFFF)) begin
      win_count_reg <= win_count_reg + 32'd1;
    end
  end

  assign win_count = win_count_reg;
`endif

  assign win_valid  = win_valid_reg;
  assign win_x      = win_x_reg;
  assign win_y      = win_y_reg;
  assign frame_done = frame_done_reg;
  assign sof_err    = sof_err_reg;

endmodule
